// File: rtl/quad_decoder.sv
// Quadrature decoder: 2-flop sync, per-channel glitch filter, INIT/TRACK step/direction FSM.
// Optional saturating illegal-transition counter enabled by QUAD_DECODER_ERR_COUNT_EN.
module quad_decoder #(
    parameter int unsigned FILT_LEN = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_in,
    input  logic       b_in,
    output logic       step,
    output logic       up_down,
    output logic       err,
    output logic [7:0] err_count
);

    localparam logic [3:0] FiltMax = 4'(FILT_LEN);

    typedef enum logic {StInit, StTrack} state_e;

    // Bit 1 is channel A, bit 0 is channel B, so filt_q reads as {A,B}.
    logic [1:0]      sync1_q, sync2_q;
    logic [1:0]      cand_q, cand_d;
    logic [1:0]      filt_q, filt_d;
    logic [1:0][3:0] run_q, run_d;
    logic [1:0]      ref_q, ref_d;
    state_e          state_q, state_d;
    logic            step_q, step_d;
    logic            err_q, err_d;
    logic            up_down_q, up_down_d;
    logic            stable;
    logic [1:0]      pos_new, pos_ref;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= 2'b00;
            sync2_q   <= 2'b00;
            cand_q    <= 2'b00;
            filt_q    <= 2'b00;
            run_q     <= '0;
            ref_q     <= 2'b00;
            state_q   <= StInit;
            step_q    <= 1'b0;
            err_q     <= 1'b0;
            up_down_q <= 1'b0;
        end else begin
            sync1_q   <= {a_in, b_in};
            sync2_q   <= sync1_q;
            cand_q    <= cand_d;
            filt_q    <= filt_d;
            run_q     <= run_d;
            ref_q     <= ref_d;
            state_q   <= state_d;
            step_q    <= step_d;
            err_q     <= err_d;
            up_down_q <= up_down_d;
        end
    end

    // run_q is the length of the current run of equal samples, saturating at FILT_LEN.
    always_comb begin
        cand_d = cand_q;
        run_d  = run_q;
        filt_d = filt_q;
        for (int i = 0; i < 2; i++) begin
            if (run_q[i] == 4'd0 || sync2_q[i] != cand_q[i]) begin
                cand_d[i] = sync2_q[i];
                run_d[i]  = 4'd1;
            end else if (run_q[i] != FiltMax) begin
                run_d[i] = run_q[i] + 4'd1;
            end
            if (run_d[i] == FiltMax) begin
                filt_d[i] = cand_d[i];
            end
        end
    end

    assign stable = (run_q[1] == FiltMax) && (run_q[0] == FiltMax);

    // Gray {A,B} to position on the forward cycle 00,01,11,10.
    assign pos_new = {filt_q[1], filt_q[1] ^ filt_q[0]};
    assign pos_ref = {ref_q[1], ref_q[1] ^ ref_q[0]};

    always_comb begin
        state_d   = state_q;
        ref_d     = ref_q;
        step_d    = 1'b0;
        err_d     = 1'b0;
        up_down_d = up_down_q;
        unique case (state_q)
            StInit: begin
                if (stable) begin
                    ref_d   = filt_q;
                    state_d = StTrack;
                end
            end
            StTrack: begin
                if (filt_q != ref_q) begin
                    ref_d = filt_q;
                    if (&(filt_q ^ ref_q)) begin
                        err_d = 1'b1;
                    end else begin
                        step_d    = 1'b1;
                        up_down_d = ((pos_new - pos_ref) == 2'd1);
                    end
                end
            end
        endcase
    end

    assign step    = step_q;
    assign err     = err_q;
    assign up_down = up_down_q;

`ifdef QUAD_DECODER_ERR_COUNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_q <= 8'h00;
        end else if (err_d && err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: window-based behavioural model checked every cycle, plus directed
// literal checks for latency, direction, glitch rejection, error counting and reset.
module tb_quad_decoder;

    localparam int FL = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       a_in, b_in;
    logic       step, up_down, err;
    logic [7:0] err_count;

    int vectors = 0;
    int miscompares = 0;
    int step_seen = 0, up_seen = 0, dn_seen = 0, err_seen = 0;

    quad_decoder #(.FILT_LEN(FL)) dut (
        .clk       (clk),
        .reset     (reset),
        .a_in      (a_in),
        .b_in      (b_in),
        .step      (step),
        .up_down   (up_down),
        .err       (err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: inputs reach the filters two edges late; a channel's filtered level is
    // the value of the last FL samples whenever they all agree.
    bit         a_d1, a_d2, b_d1, b_d2;
    bit         wa[$], wb[$];
    bit         m_filt_a, m_filt_b, m_stab_a, m_stab_b, m_track, model_ok;
    logic [1:0] m_ref, m_cur;
    int         m_dist;
    bit         exp_step, exp_err, exp_ud;
    int         exp_cnt;

    function automatic int pos(input logic [1:0] c);
        case (c)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    always @(posedge clk) begin
        model_ok = 1'b1;
        if (reset) begin
            a_d1 = 0; a_d2 = 0; b_d1 = 0; b_d2 = 0;
            wa.delete(); wb.delete();
            m_filt_a = 0; m_filt_b = 0; m_stab_a = 0; m_stab_b = 0;
            m_track = 0; m_ref = 2'b00;
            exp_step = 0; exp_err = 0; exp_ud = 0; exp_cnt = 0;
        end else begin
            exp_step = 0;
            exp_err  = 0;
            m_cur    = {m_filt_a, m_filt_b};
            if (!m_track) begin
                if (m_stab_a && m_stab_b) begin
                    m_ref   = m_cur;
                    m_track = 1;
                end
            end else if (m_cur != m_ref) begin
                m_dist = (pos(m_cur) - pos(m_ref) + 4) % 4;
                if (m_dist == 2) begin
                    exp_err = 1;
`ifdef QUAD_DECODER_ERR_COUNT_EN
                    if (exp_cnt < 255) exp_cnt++;
`endif
                end else begin
                    exp_step = 1;
                    exp_ud   = (m_dist == 1);
                end
                m_ref = m_cur;
            end
            wa.push_back(a_d2);
            wb.push_back(b_d2);
            if (wa.size() > FL) void'(wa.pop_front());
            if (wb.size() > FL) void'(wb.pop_front());
            a_d2 = a_d1; a_d1 = a_in;
            b_d2 = b_d1; b_d1 = b_in;
            m_stab_a = (wa.size() == FL);
            foreach (wa[i]) if (wa[i] != wa[0]) m_stab_a = 0;
            m_stab_b = (wb.size() == FL);
            foreach (wb[i]) if (wb[i] != wb[0]) m_stab_b = 0;
            if (m_stab_a) m_filt_a = wa[0];
            if (m_stab_b) m_filt_b = wb[0];
        end
    end

    // Every wait in the stimulus goes through here, so every cycle is compared.
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            if (model_ok) begin
                vectors++;
                if (step !== exp_step || err !== exp_err || up_down !== exp_ud ||
                    err_count !== 8'(exp_cnt)) begin
                    miscompares++;
                    $display("FAIL model t=%0t: got step=%b err=%b up_down=%b err_count=%0d, want step=%b err=%b up_down=%b err_count=%0d",
                             $time, step, err, up_down, err_count,
                             exp_step, exp_err, exp_ud, exp_cnt);
                end
            end
            if (step === 1'b1) begin
                step_seen++;
                if (up_down === 1'b1) up_seen++; else dn_seen++;
            end
            if (err === 1'b1) err_seen++;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic restart(input logic a, input logic b);
        reset = 1'b1;
        a_in  = a;
        b_in  = b;
        tick(2);
        reset = 1'b0;
        tick(20);
    endtask

    initial begin
        int s0, e0, u0, d0, lat, cnt_exp;
        logic [1:0] fwd[4];
        logic [1:0] seq[4];

        reset = 1'b1; a_in = 1'b1; b_in = 1'b1;
        tick(3);
        check("reset_step", int'(step), 0);
        check("reset_err", int'(err), 0);
        check("reset_up_down", int'(up_down), 0);
        check("reset_err_count", int'(err_count), 0);
        reset = 1'b0;
        s0 = step_seen; e0 = err_seen;
        tick(20);
        check("init_no_step", step_seen - s0, 0);
        check("init_no_err", err_seen - e0, 0);
        check("init_up_down", int'(up_down), 0);

        // Forward cycle, measuring input-edge to step latency.
        restart(1'b0, 1'b0);
        fwd[0] = 2'b01; fwd[1] = 2'b11; fwd[2] = 2'b10; fwd[3] = 2'b00;
        s0 = step_seen; u0 = up_seen; e0 = err_seen;
        for (int i = 0; i < 4; i++) begin
            {a_in, b_in} = fwd[i];
            lat = 0;
            while (lat < 20) begin
                tick(1);
                lat++;
                if (step === 1'b1) break;
            end
            check("fwd_latency", lat, 6);
            if (lat < 10) tick(10 - lat);
        end
        check("fwd_steps", step_seen - s0, 4);
        check("fwd_up_steps", up_seen - u0, 4);
        check("fwd_no_err", err_seen - e0, 0);
        check("fwd_up_down", int'(up_down), 1);

        // Three reverse, then one forward.
        seq[0] = 2'b10; seq[1] = 2'b11; seq[2] = 2'b01; seq[3] = 2'b11;
        u0 = up_seen; d0 = dn_seen;
        for (int i = 0; i < 3; i++) begin
            {a_in, b_in} = seq[i];
            tick(10);
        end
        check("rev_dn_steps", dn_seen - d0, 3);
        check("rev_up_down", int'(up_down), 0);
        {a_in, b_in} = seq[3];
        tick(10);
        check("rev_then_fwd_up", up_seen - u0, 1);
        check("rev_then_fwd_up_down", int'(up_down), 1);

        // Two-cycle glitch on A must be swallowed; then 00->01 must still read as forward.
        restart(1'b0, 1'b0);
        s0 = step_seen; e0 = err_seen;
        a_in = 1'b1; tick(2); a_in = 1'b0; tick(20);
        check("glitch_no_step", step_seen - s0, 0);
        check("glitch_no_err", err_seen - e0, 0);
        u0 = up_seen;
        b_in = 1'b1; tick(10);
        check("glitch_then_fwd", up_seen - u0, 1);

        // Both channels toggling together: illegal every time.
        restart(1'b0, 1'b0);
        s0 = step_seen; e0 = err_seen;
        for (int i = 0; i < 300; i++) begin
            a_in = ~a_in; b_in = ~b_in;
            tick(10);
        end
        check("toggle_errs", err_seen - e0, 300);
        check("toggle_no_step", step_seen - s0, 0);
`ifdef QUAD_DECODER_ERR_COUNT_EN
        cnt_exp = 255;
`else
        cnt_exp = 0;
`endif
        check("toggle_err_count", int'(err_count), cnt_exp);

        // Reset lands two cycles after an edge, before its step.
        b_in = 1'b1; tick(10);
        check("pre_reset_up_down", int'(up_down), 1);
        s0 = step_seen;
        a_in = 1'b1; tick(2);
        reset = 1'b1; tick(1);
        check("midreset_step", int'(step), 0);
        check("midreset_err", int'(err), 0);
        check("midreset_up_down", int'(up_down), 0);
        check("midreset_err_count", int'(err_count), 0);
        tick(2);
        reset = 1'b0;
        tick(20);
        check("midreset_no_step", step_seen - s0, 0);

        // Random input activity with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1; tick($urandom_range(1, 3)); reset = 1'b0;
            end
            a_in = 1'($urandom_range(0, 1));
            b_in = 1'($urandom_range(0, 1));
            tick($urandom_range(1, 10));
        end
        tick(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
